// File: rtl/btn_conditioner_pkg.sv
// ---------------------------------------------------------------------------
// btn_conditioner_pkg : button indices and default timing for btn_conditioner
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package btn_conditioner_pkg;

  localparam int NUM_BTNS  = 4;

  localparam int BTN_P1_UP = 0;
  localparam int BTN_P1_DN = 1;
  localparam int BTN_P2_UP = 2;
  localparam int BTN_P2_DN = 3;

  // 10 ms debounce and 100 ms auto-repeat at 25 MHz
  localparam int DEFAULT_DEBOUNCE_CYCLES = 250000;
  localparam int DEFAULT_REPEAT_CYCLES   = 2500000;

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce : 2-flop synchronizer, debounce counter, level and press pulse
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module btn_debounce
  import btn_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_press,
  output logic o_toggle
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] c_CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);

  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_press;
  logic             w_diff;

  assign w_diff   = r_sync2 ^ r_level;
  // Level commits on the edge after DEBOUNCE_CYCLES differing samples were counted.
  assign o_toggle = w_diff && (r_cnt == c_CNT_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (!w_diff || o_toggle) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (o_toggle) begin
        r_level <= ~r_level;
      end
      r_press <= o_toggle & ~r_level;
    end
  end

  assign o_level = r_level;
  assign o_press = r_press;

endmodule

`default_nettype wire

// File: rtl/btn_conditioner.sv
// ---------------------------------------------------------------------------
// btn_conditioner : debounced buttons, press pulses and auto-repeat move strobes
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module btn_conditioner
  import btn_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_raw,
  output logic [3:0] btn_level,
  output logic [3:0] btn_press,
  output logic [3:0] move
);

  localparam int REP_W = $clog2(REPEAT_CYCLES);
  localparam logic [REP_W-1:0] c_REP_LAST = REP_W'(REPEAT_CYCLES - 1);

  logic [NUM_BTNS-1:0] w_toggle;
  logic [NUM_BTNS-1:0] w_level_nxt;
  logic [NUM_BTNS-1:0] w_rise;
  logic [NUM_BTNS-1:0] w_wrap;
  logic [NUM_BTNS-1:0] w_mask;
  logic                w_conf_p1;
  logic                w_conf_p2;
  logic [NUM_BTNS-1:0] r_move;

  assign w_level_nxt = btn_level ^ w_toggle;
  assign w_rise      = w_toggle & ~btn_level;

  for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
    logic [REP_W-1:0] r_rep;

    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_raw   (btn_raw[gi]),
      .o_level (btn_level[gi]),
      .o_press (btn_press[gi]),
      .o_toggle(w_toggle[gi])
    );

    assign w_wrap[gi] = btn_level[gi] & ~w_toggle[gi] & (r_rep == c_REP_LAST);

    // Counter phase is anchored to the press, so repeats keep their cadence through conflicts.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_rep <= '0;
      end else if (w_rise[gi]) begin
        r_rep <= '0;
      end else if (btn_level[gi] && !w_toggle[gi]) begin
        r_rep <= w_wrap[gi] ? '0 : r_rep + REP_W'(1);
      end else begin
        r_rep <= '0;
      end
    end
  end

  // Masking uses next-cycle levels so move lines up with the registered level.
  assign w_conf_p1 = w_level_nxt[BTN_P1_UP] & w_level_nxt[BTN_P1_DN];
  assign w_conf_p2 = w_level_nxt[BTN_P2_UP] & w_level_nxt[BTN_P2_DN];

  assign w_mask[BTN_P1_UP] = w_conf_p1;
  assign w_mask[BTN_P1_DN] = w_conf_p1;
  assign w_mask[BTN_P2_UP] = w_conf_p2;
  assign w_mask[BTN_P2_DN] = w_conf_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_move <= '0;
    end else begin
      r_move <= (w_rise | w_wrap) & ~w_mask;
    end
  end

  assign move = r_move;

endmodule

`default_nettype wire
